// File: rtl/io_serial_pkg.sv
// Shared definitions for the 1-bit serial pad controller: FSM encoding,
// frame geometry and configuration register constants.
package io_serial_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TX_START,
      TX_DATA,
      TX_STOP,
      RX_START,
      RX_DATA,
      RX_STOP
   } state_t;

   localparam int         FRAME_BITS   = 10;
   localparam int         DATA_BITS    = FRAME_BITS - 2;
   localparam logic [7:0] CFG_REG_ADDR = 8'd0;
   localparam logic [7:0] CLK_DIV_RST  = 8'd15;
   localparam logic [1:0] TX_FLUSH     = 2'd2;

   // A divider of 0 would give a 1-cycle bit with no distinct mid point.
   function automatic logic [7:0] eff_div(input logic [7:0] d);
      return (d == 8'd0) ? 8'd1 : d;
   endfunction

endpackage

// File: rtl/io_bit_timer.sv
// Bit-period counter shared by transmit and receive: counts 0..div, held
// at zero while restart is high, strobes at the mid point and the last cycle.
module io_bit_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       restart,
   input  logic [7:0] div,
   output logic       mid,
   output logic       last
);

   logic [7:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (restart || (cnt == div)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

   assign mid  = (cnt == (div >> 1));
   assign last = (cnt == div);

endmodule

// File: rtl/io1bit_serial_ctrl.sv
// Half-duplex 1-bit pad controller: UART-style framing (start, 8 data LSB
// first, stop) with RX start priority over TX and a config-bus register.
module io1bit_serial_ctrl
   import io_serial_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] config_addr,
   input  logic [31:0] config_data,
   input  logic [15:0] tile_id,
   output logic        f2p,
   output logic        mode,
   input  logic        p2f,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        rx_err
);

   localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

   state_t      state, nxt;
   logic        enable;
   logic [7:0]  clk_div;
   logic [7:0]  div_eff;
   logic        cfg_we, en_nxt;
   logic        p2f_p0, p2f_p1, p2f_p2;
   logic        rx_start, tx_fire;
   logic [1:0]  blk_cnt;
   logic [2:0]  bit_idx;
   logic        bit_last;
   logic [7:0]  tx_shreg, rx_shreg;
   logic        tmr_mid, tmr_last;
   logic        unused_cfg;

   assign unused_cfg = ^{config_addr[31:24], config_data[31:16], config_data[7:1]};

   assign cfg_we = (config_addr[15:0] == tile_id) && (config_addr[23:16] == CFG_REG_ADDR);
   // Enable as it will be after this edge, so a clearing write aborts at once.
   assign en_nxt = cfg_we ? config_data[0] : enable;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enable  <= 1'b0;
         clk_div <= CLK_DIV_RST;
      end else if (cfg_we) begin
         enable  <= config_data[0];
         clk_div <= config_data[15:8];
      end
   end

   assign div_eff = eff_div(clk_div);

   // Pad input synchronizer, plus one extra flop for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p2f_p0 <= 1'b1;
         p2f_p1 <= 1'b1;
         p2f_p2 <= 1'b1;
      end else begin
         p2f_p0 <= p2f;
         p2f_p1 <= p2f_p0;
         p2f_p2 <= p2f_p1;
      end
   end

   assign rx_start = (state == IDLE) && enable && (blk_cnt == 2'd0) && p2f_p2 && !p2f_p1;
   assign tx_fire  = tx_valid && tx_ready;
   assign bit_last = (bit_idx == LAST_IDX);

   io_bit_timer u_timer (
      .clk     (clk),
      .reset   (reset),
      .restart (state == IDLE),
      .div     (div_eff),
      .mid     (tmr_mid),
      .last    (tmr_last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE: begin
            if (rx_start)     nxt = RX_START;
            else if (tx_fire) nxt = TX_START;
         end
         TX_START: if (tmr_last)             nxt = TX_DATA;
         TX_DATA:  if (tmr_last && bit_last) nxt = TX_STOP;
         TX_STOP:  if (tmr_last)             nxt = IDLE;
         RX_START: begin
            if (tmr_mid && p2f_p1) nxt = IDLE;
            else if (tmr_last)     nxt = RX_DATA;
         end
         RX_DATA:  if (tmr_last && bit_last) nxt = RX_STOP;
         RX_STOP:  if (tmr_mid)              nxt = IDLE;
         default:  nxt = IDLE;
      endcase
      if (!en_nxt) nxt = IDLE;
   end

   always_comb begin
      mode     = 1'b0;
      f2p      = 1'b1;
      tx_ready = (state == IDLE) && enable && !rx_start;
      case (state)
         TX_START: begin mode = 1'b1; f2p = 1'b0;              end
         TX_DATA:  begin mode = 1'b1; f2p = tx_shreg[bit_idx]; end
         TX_STOP:  begin mode = 1'b1; f2p = 1'b1;              end
         default:  ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_idx  <= '0;
         blk_cnt  <= '0;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         rx_data  <= '0;
      end else begin
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         if (((state == TX_DATA) || (state == RX_DATA)) && tmr_last) begin
            bit_idx <= bit_idx + 3'd1;
         end else if ((state != TX_DATA) && (state != RX_DATA)) begin
            bit_idx <= '0;
         end
         // Our own stop bit echoes through the synchronizer; mask it.
         if ((state == TX_STOP) && tmr_last) begin
            blk_cnt <= TX_FLUSH;
         end else if (blk_cnt != 2'd0) begin
            blk_cnt <= blk_cnt - 2'd1;
         end
         if ((state == RX_STOP) && tmr_mid && en_nxt) begin
            if (p2f_p1) begin
               rx_valid <= 1'b1;
               rx_data  <= rx_shreg;
            end else begin
               rx_err   <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (tx_fire) tx_shreg <= tx_data;
      if ((state == RX_DATA) && tmr_mid) rx_shreg[bit_idx] <= p2f_p1;
   end

endmodule

// File: tb/tb_io1bit_serial_ctrl.sv
// Directed bench for io1bit_serial_ctrl: TX/RX framing, errors, collision,
// aborts and config decode, with hand-derived expectations.
module tb_io1bit_serial_ctrl;

   localparam logic [15:0] TILE     = 16'h0005;
   localparam logic [31:0] ADDR_OK  = {8'h00, 8'h00, TILE};
   localparam logic [31:0] ADDR_IDL = 32'hFFFF_FFFF;

   logic        clk, reset;
   logic [31:0] config_addr, config_data;
   logic [15:0] tile_id;
   logic        f2p, mode, p2f;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_err;

   int n_pass, n_total;

   logic f2p_log  [0:63];
   logic mode_log [0:63];
   logic rdy_log  [0:63];

   int         rxv_cnt, rxe_cnt, mode_cnt, rdy_mid_cnt, acc_t;
   logic [7:0] rx_cap;
   logic       rdy_t2;

   io1bit_serial_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .config_addr (config_addr),
      .config_data (config_data),
      .tile_id     (tile_id),
      .f2p         (f2p),
      .mode        (mode),
      .p2f         (p2f),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_err      (rx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
      config_addr = addr;
      config_data = data;
      @(negedge clk);
      config_addr = ADDR_IDL;
      config_data = '0;
   endtask

   // Log index 0 is the first cycle after the handshake edge.
   task automatic tx_capture(input logic [7:0] d, input int ncyc);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      for (int i = 0; i < ncyc; i++) begin
         f2p_log[i]  = f2p;
         mode_log[i] = mode;
         rdy_log[i]  = tx_ready;
         @(negedge clk);
      end
   endtask

   // Drives one frame at 8 cycles per bit; t=0 drives the start bit.
   task automatic rx_frame(input logic [7:0] d, input logic stop, input bit collide);
      logic [9:0] bits;
      logic       drop;
      bits = {stop, d, 1'b0};
      rxv_cnt = 0; rxe_cnt = 0; mode_cnt = 0; rdy_mid_cnt = 0;
      acc_t = -1; rdy_t2 = 1'bx; drop = 1'b0;
      for (int t = 0; t < 92; t++) begin
         if (rx_valid) begin rxv_cnt++; rx_cap = rx_data; end
         if (rx_err) rxe_cnt++;
         if ((t < 80) && mode) mode_cnt++;
         if ((t >= 3) && (t <= 78) && tx_ready) rdy_mid_cnt++;
         if (t == 2) rdy_t2 = tx_ready;
         if (drop) tx_valid = 1'b0;
         drop = 1'b0;
         if (tx_valid && tx_ready) begin acc_t = t; drop = 1'b1; end
         if (collide && (t == 2)) begin tx_data = 8'h5A; tx_valid = 1'b1; end
         p2f = (t < 80) ? bits[t/8] : 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_total++; if (mode !== 1'b0)     $display("FAIL reset_mode: got %b want 0", mode); else n_pass++;
      n_total++; if (f2p !== 1'b1)      $display("FAIL reset_f2p: got %b want 1", f2p); else n_pass++;
      n_total++; if (tx_ready !== 1'b0) $display("FAIL reset_tx_ready: got %b want 0", tx_ready); else n_pass++;
      n_total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else n_pass++;
      n_total++; if (rx_err !== 1'b0)   $display("FAIL reset_rx_err: got %b want 0", rx_err); else n_pass++;
      n_total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else n_pass++;
      reset = 1'b0;
      @(negedge clk);
      n_total++; if (tx_ready !== 1'b0) $display("FAIL reset_disabled_ready: got %b want 0", tx_ready); else n_pass++;
   endtask

   task automatic test_tx();
      logic [9:0] frame;
      int hi, rdy;
      frame = {1'b1, 8'hA5, 1'b0};
      cfg_write(ADDR_OK, {16'h0000, 8'd3, 8'h01});
      n_total++; if (tx_ready !== 1'b1) $display("FAIL tx_ready_idle: got %b want 1", tx_ready); else n_pass++;
      tx_capture(8'hA5, 44);
      hi = 0; rdy = 0;
      for (int i = 0; i < 40; i++) begin
         if (mode_log[i]) hi++;
         if (rdy_log[i]) rdy++;
         n_total++;
         if (f2p_log[i] !== frame[i/4])
            $display("FAIL tx_f2p cycle %0d: got %b want %b", i, f2p_log[i], frame[i/4]);
         else n_pass++;
      end
      n_total++; if (hi != 40)           $display("FAIL tx_mode_cycles: got %0d want 40", hi); else n_pass++;
      n_total++; if (rdy != 0)           $display("FAIL tx_ready_busy: got %0d high cycles want 0", rdy); else n_pass++;
      n_total++; if (mode_log[40] !== 1'b0) $display("FAIL tx_mode_end: got %b want 0", mode_log[40]); else n_pass++;
      n_total++; if (f2p_log[40] !== 1'b1)  $display("FAIL tx_f2p_end: got %b want 1", f2p_log[40]); else n_pass++;
   endtask

   task automatic test_rx();
      cfg_write(ADDR_OK, {16'h0000, 8'd7, 8'h01});
      repeat (3) @(negedge clk);
      rx_frame(8'h3C, 1'b1, 1'b0);
      n_total++; if (rxv_cnt != 1)     $display("FAIL rx_valid_pulses: got %0d want 1", rxv_cnt); else n_pass++;
      n_total++; if (rx_cap !== 8'h3C) $display("FAIL rx_data_pulse: got %h want 3c", rx_cap); else n_pass++;
      n_total++; if (rxe_cnt != 0)     $display("FAIL rx_err_pulses: got %0d want 0", rxe_cnt); else n_pass++;
      n_total++; if (mode_cnt != 0)    $display("FAIL rx_mode: got %0d high cycles want 0", mode_cnt); else n_pass++;
      n_total++; if (rx_data !== 8'h3C) $display("FAIL rx_data_hold: got %h want 3c", rx_data); else n_pass++;
   endtask

   task automatic test_frame_err();
      rx_frame(8'hFF, 1'b0, 1'b0);
      n_total++; if (rxe_cnt != 1)      $display("FAIL ferr_err_pulses: got %0d want 1", rxe_cnt); else n_pass++;
      n_total++; if (rxv_cnt != 0)      $display("FAIL ferr_valid_pulses: got %0d want 0", rxv_cnt); else n_pass++;
      n_total++; if (rx_data !== 8'h3C) $display("FAIL ferr_rx_data: got %h want 3c", rx_data); else n_pass++;
   endtask

   task automatic test_false_start();
      int rv, re;
      logic rdy3, rdy8;
      rv = 0; re = 0; rdy3 = 1'bx; rdy8 = 1'bx;
      for (int t = 0; t < 40; t++) begin
         if (rx_valid) rv++;
         if (rx_err) re++;
         if (t == 3) rdy3 = tx_ready;
         if (t == 8) rdy8 = tx_ready;
         p2f = (t < 2) ? 1'b0 : 1'b1;
         @(negedge clk);
      end
      n_total++; if (rdy3 !== 1'b0) $display("FAIL fstart_busy: got %b want 0", rdy3); else n_pass++;
      n_total++; if (rdy8 !== 1'b1) $display("FAIL fstart_abort_idle: got %b want 1", rdy8); else n_pass++;
      n_total++; if (rv != 0)       $display("FAIL fstart_valid: got %0d want 0", rv); else n_pass++;
      n_total++; if (re != 0)       $display("FAIL fstart_err: got %0d want 0", re); else n_pass++;
   endtask

   task automatic test_collision();
      bit done;
      rx_frame(8'hC3, 1'b1, 1'b1);
      n_total++; if (rdy_t2 !== 1'b0)  $display("FAIL coll_ready_at_start: got %b want 0", rdy_t2); else n_pass++;
      n_total++; if (rdy_mid_cnt != 0) $display("FAIL coll_ready_during_rx: got %0d want 0", rdy_mid_cnt); else n_pass++;
      n_total++; if (rxv_cnt != 1)     $display("FAIL coll_rx_valid: got %0d want 1", rxv_cnt); else n_pass++;
      n_total++; if (rx_cap !== 8'hC3) $display("FAIL coll_rx_data: got %h want c3", rx_cap); else n_pass++;
      n_total++; if (mode_cnt != 0)    $display("FAIL coll_mode_rx: got %0d want 0", mode_cnt); else n_pass++;
      n_total++; if (acc_t != 79)      $display("FAIL coll_accept_cycle: got %0d want 79", acc_t); else n_pass++;
      n_total++; if (mode !== 1'b1)    $display("FAIL coll_tx_running: got %b want 1", mode); else n_pass++;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         if (mode === 1'b0) done = 1'b1;
         else @(negedge clk);
      end
      n_total++; if (!done) $display("FAIL coll_tx_finish: got timeout want mode 0"); else n_pass++;
   endtask

   task automatic test_abort_tx();
      cfg_write(ADDR_OK, {16'h0000, 8'd3, 8'h01});
      n_total++; if (tx_ready !== 1'b1) $display("FAIL abort_ready_pre: got %b want 1", tx_ready); else n_pass++;
      tx_data  = 8'hA5;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (16) @(negedge clk);
      n_total++; if (mode !== 1'b1) $display("FAIL abort_mode_pre: got %b want 1", mode); else n_pass++;
      n_total++; if (f2p !== 1'b0)  $display("FAIL abort_f2p_bit4: got %b want 0", f2p); else n_pass++;
      cfg_write(ADDR_OK, {16'h0000, 8'd3, 8'h00});
      n_total++; if (mode !== 1'b0)     $display("FAIL abort_mode: got %b want 0", mode); else n_pass++;
      n_total++; if (tx_ready !== 1'b0) $display("FAIL abort_ready: got %b want 0", tx_ready); else n_pass++;
      n_total++; if (f2p !== 1'b1)      $display("FAIL abort_f2p: got %b want 1", f2p); else n_pass++;
      @(negedge clk);
      n_total++; if (mode !== 1'b0)     $display("FAIL abort_mode_hold: got %b want 0", mode); else n_pass++;
   endtask

   task automatic test_abort_reset();
      cfg_write(ADDR_OK, {16'h0000, 8'd7, 8'h01});
      @(negedge clk);
      p2f = 1'b0;
      repeat (20) @(negedge clk);
      n_total++; if (tx_ready !== 1'b0) $display("FAIL rrst_busy: got %b want 0", tx_ready); else n_pass++;
      n_total++; if (rx_data !== 8'hC3) $display("FAIL rrst_data_pre: got %h want c3", rx_data); else n_pass++;
      #2 reset = 1'b1;
      #1;
      n_total++; if (mode !== 1'b0)     $display("FAIL rrst_mode: got %b want 0", mode); else n_pass++;
      n_total++; if (f2p !== 1'b1)      $display("FAIL rrst_f2p: got %b want 1", f2p); else n_pass++;
      n_total++; if (tx_ready !== 1'b0) $display("FAIL rrst_ready: got %b want 0", tx_ready); else n_pass++;
      n_total++; if (rx_valid !== 1'b0) $display("FAIL rrst_valid: got %b want 0", rx_valid); else n_pass++;
      n_total++; if (rx_err !== 1'b0)   $display("FAIL rrst_err: got %b want 0", rx_err); else n_pass++;
      n_total++; if (rx_data !== 8'h00) $display("FAIL rrst_data: got %h want 00", rx_data); else n_pass++;
      @(negedge clk);
      p2f = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_cfg_decode();
      logic [9:0] frame;
      int hi;
      frame = {1'b1, 8'h81, 1'b0};
      cfg_write({8'h00, 8'h01, TILE}, 32'h0000_0001);
      n_total++; if (tx_ready !== 1'b0) $display("FAIL cfg_bad_reg: got %b want 0", tx_ready); else n_pass++;
      cfg_write({16'h0000, TILE ^ 16'h0001}, 32'h0000_0001);
      n_total++; if (tx_ready !== 1'b0) $display("FAIL cfg_bad_tile: got %b want 0", tx_ready); else n_pass++;
      cfg_write(ADDR_OK, 32'h0000_0001);
      n_total++; if (tx_ready !== 1'b1) $display("FAIL cfg_good: got %b want 1", tx_ready); else n_pass++;
      tx_capture(8'h81, 24);
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         if (mode_log[i]) hi++;
         n_total++;
         if (f2p_log[i] !== frame[i/2])
            $display("FAIL div0_f2p cycle %0d: got %b want %b", i, f2p_log[i], frame[i/2]);
         else n_pass++;
      end
      n_total++; if (hi != 20)              $display("FAIL div0_mode_cycles: got %0d want 20", hi); else n_pass++;
      n_total++; if (mode_log[20] !== 1'b0) $display("FAIL div0_mode_end: got %b want 0", mode_log[20]); else n_pass++;
   endtask

   initial begin
      n_pass      = 0;
      n_total     = 0;
      reset       = 1'b1;
      config_addr = ADDR_IDL;
      config_data = '0;
      tile_id     = TILE;
      p2f         = 1'b1;
      tx_data     = '0;
      tx_valid    = 1'b0;
      @(negedge clk);
      test_reset();
      test_tx();
      test_rx();
      test_frame_err();
      test_false_start();
      test_collision();
      test_abort_tx();
      test_abort_reset();
      test_cfg_decode();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
